// File: rtl/s298_pkg.sv
// Shared constants for the s298 state bank: state-bit layout, observable
// bit selection, run-controller states and the MISR polynomial.
package s298_pkg;

  localparam int unsigned NSTATE = 14;
  localparam int unsigned NOBS   = 6;

  // Position of each s298 state bit inside cur_state / next_state.
  localparam int unsigned G10  = 0;
  localparam int unsigned G11  = 1;
  localparam int unsigned G12  = 2;
  localparam int unsigned G13  = 3;
  localparam int unsigned G14  = 4;
  localparam int unsigned G15  = 5;
  localparam int unsigned G22  = 6;
  localparam int unsigned G23  = 7;
  localparam int unsigned G66  = 8;
  localparam int unsigned G67  = 9;
  localparam int unsigned G117 = 10;
  localparam int unsigned G118 = 11;
  localparam int unsigned G132 = 12;
  localparam int unsigned G133 = 13;

  // obs[i] = cur_state[OBS_IDX[i]]; obs[5:0] = {G67,G133,G66,G132,G118,G117}.
  localparam int unsigned OBS_IDX [0:NOBS-1] = '{G117, G118, G132, G66, G133, G67};

  localparam logic [15:0] MISR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  function automatic logic [NOBS-1:0] obs_bits(input logic [NSTATE-1:0] s);
    logic [NOBS-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < NOBS; i++) begin
      o[i] = s[OBS_IDX[i]];
    end
    return o;
  endfunction

endpackage

// File: rtl/s298_state_bank_if.sv
// Bundle of run-control, comb-block and result signals of the s298 state bank.
// master = the controlling environment, slave = the state bank itself.
interface s298_state_bank_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned MISR_W = 16
);

  logic                         start;
  logic                         start_ready;
  logic [s298_pkg::NSTATE-1:0]  seed;
  logic [CNT_W-1:0]             n_cycles;
  logic [2:0]                   pi_in;
  logic                         pi_valid;
  logic                         pi_ready;
  logic                         abort;
  logic [s298_pkg::NSTATE-1:0]  cur_state;
  logic [2:0]                   comb_pi;
  logic [s298_pkg::NSTATE-1:0]  next_state;
  logic                         done;
  logic                         done_ack;
  logic [MISR_W-1:0]            signature;
  logic [CNT_W-1:0]             steps_taken;

  modport master (
    output start, seed, n_cycles, pi_in, pi_valid, abort, next_state, done_ack,
    input  start_ready, pi_ready, cur_state, comb_pi, done, signature, steps_taken
  );

  modport slave (
    input  start, seed, n_cycles, pi_in, pi_valid, abort, next_state, done_ack,
    output start_ready, pi_ready, cur_state, comb_pi, done, signature, steps_taken
  );

endinterface

// File: rtl/s298_misr.sv
// Galois MISR: shift with polynomial feedback, then fold in the input word.
// clr has priority over en.
module s298_misr #(
  parameter int unsigned        MISR_W    = 16,
  parameter int unsigned        IN_W      = 6,
  parameter logic [MISR_W-1:0]  MISR_POLY = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_W-1:0]   din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] shifted;
  logic [MISR_W-1:0] sig_next;

  // Next-signature function.
  always_comb begin
    shifted  = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0);
    sig_next = shifted ^ MISR_W'(din);
  end

  // Signature register with synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/s298_state_bank.sv
// State bank and run controller around the s298 combinational netlist:
// holds the 14 state flops, sequences N-step runs from a seed and
// compresses the observable state bits into a MISR signature.
module s298_state_bank #(
  parameter int unsigned        CNT_W     = 16,
  parameter int unsigned        MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = s298_pkg::MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  s298_state_bank_if.slave      bus
);

  import s298_pkg::*;

  fsm_t              fsm_q;
  logic [NSTATE-1:0] state_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  steps_q;
  logic              start_ready_q;
  logic              pi_ready_q;
  logic              done_q;

  logic              misr_clr;
  logic              misr_en;
  logic [NOBS-1:0]   obs;

  // Start acceptance clears the signature; a step (not pre-empted by abort)
  // folds in the pre-step observable bits.
  always_comb begin
    misr_clr = (fsm_q == ST_IDLE) && bus.start;
    misr_en  = (fsm_q == ST_RUN) && bus.pi_valid && !bus.abort;
    obs      = obs_bits(state_q);
  end

  // Run controller and state bank; handshake outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ST_IDLE;
      state_q       <= '0;
      remaining_q   <= '0;
      steps_q       <= '0;
      start_ready_q <= 1'b1;
      pi_ready_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q       <= bus.seed;
            steps_q       <= '0;
            remaining_q   <= bus.n_cycles;
            start_ready_q <= 1'b0;
            if (bus.n_cycles == '0) begin
              fsm_q  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q      <= ST_RUN;
              pi_ready_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            fsm_q         <= ST_IDLE;
            pi_ready_q    <= 1'b0;
            start_ready_q <= 1'b1;
          end else if (bus.pi_valid) begin
            state_q     <= bus.next_state;
            remaining_q <= remaining_q - CNT_W'(1);
            if (steps_q != '1) begin
              steps_q <= steps_q + CNT_W'(1);
            end
            if (remaining_q == CNT_W'(1)) begin
              fsm_q      <= ST_DONE;
              pi_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.done_ack) begin
            fsm_q         <= ST_IDLE;
            done_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
        end
      endcase
    end
  end

  s298_misr #(
    .MISR_W    (MISR_W),
    .IN_W      (NOBS),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (obs),
    .sig (bus.signature)
  );

  assign bus.cur_state   = state_q;
  assign bus.comb_pi     = bus.pi_in;
  assign bus.start_ready = start_ready_q;
  assign bus.pi_ready    = pi_ready_q;
  assign bus.done        = done_q;
  assign bus.steps_taken = steps_q;

endmodule

// File: tb/tb_s298_state_bank.sv
// Directed bench for s298_state_bank. A stand-in next-state function plays
// the comb block; expected run results come from an independent step model.
module tb_s298_state_bank;

  logic clk;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;

  s298_state_bank_if bus ();

  s298_state_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in comb block: deterministic mixing of state and primary inputs.
  function automatic logic [13:0] comb_f(input logic [13:0] s, input logic [2:0] g);
    logic [13:0] r;
    r     = {s[12:0], s[13] ^ s[9] ^ g[0]};
    r[7]  = r[7] ^ g[1];
    r[11] = r[11] ^ (s[2] & g[2]);
    if (s[5]) r = r ^ 14'h2C81;
    return r;
  endfunction

  assign bus.next_state = comb_f(bus.cur_state, bus.comb_pi);

  // Reference: k steps with pi=3'b001 from seed; MISR over pre-step obs bits.
  task automatic model(input logic [13:0] seed, input int unsigned k,
                       output logic [13:0] st, output logic [15:0] sg);
    logic [5:0] o;
    st = seed;
    sg = 16'h0;
    for (int unsigned i = 0; i < k; i++) begin
      o  = {st[9], st[13], st[8], st[12], st[11], st[10]};
      sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'hB400 : 16'h0000) ^ {10'b0, o};
      st = comb_f(st, 3'b001);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [13:0] s, input logic [15:0] n);
    bus.seed     = s;
    bus.n_cycles = n;
    bus.pi_in    = 3'b001;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Cycle 0 is the start cycle; returns the cycle in which done is first seen.
  task automatic wait_done(input bit alt, output int unsigned cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      bus.pi_valid = alt ? cyc[0] : 1'b1;
      tick();
      cyc++;
    end
    bus.pi_valid = 1'b0;
  endtask

  task automatic ack();
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0]  exp_st;
    logic [15:0]  exp_sg;
    int unsigned  cyc;
    localparam logic [13:0] SEED_A = 14'h2A5C;
    localparam logic [13:0] SEED_B = 14'h0F31;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.seed     = '0;
    bus.n_cycles = '0;
    bus.pi_in    = 3'b000;
    bus.pi_valid = 1'b0;
    bus.abort    = 1'b0;
    bus.done_ack = 1'b0;

    // Reset values.
    #12;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_pi_ready",    bus.pi_ready,    0);
    check("rst_done",        bus.done,        0);
    check("rst_cur_state",   bus.cur_state,   0);
    check("rst_signature",   bus.signature,   0);
    check("rst_steps",       bus.steps_taken, 0);
    tick();
    rst = 1'b0;
    tick();

    // 10-step run, continuous pi_valid.
    model(SEED_A, 10, exp_st, exp_sg);
    start_run(SEED_A, 16'd10);
    check("run10_pi_ready", bus.pi_ready, 1);
    check("run10_comb_pi",  bus.comb_pi,  3'b001);
    wait_done(1'b0, cyc);
    check("run10_done_cycle", cyc,             11);
    check("run10_state",      bus.cur_state,   exp_st);
    check("run10_sig",        bus.signature,   exp_sg);
    check("run10_steps",      bus.steps_taken, 10);
    check("run10_pi_ready_d", bus.pi_ready,    0);
    ack();
    check("ack_start_ready", bus.start_ready, 1);
    check("ack_done",        bus.done,        0);

    // n_cycles = 0: straight to DONE, signature cleared from previous run.
    start_run(14'h1234, 16'd0);
    check("n0_done",     bus.done,        1);
    check("n0_pi_ready", bus.pi_ready,    0);
    check("n0_state",    bus.cur_state,   14'h1234);
    check("n0_sig",      bus.signature,   0);
    check("n0_steps",    bus.steps_taken, 0);
    ack();

    // Same run with pi_valid on alternate cycles.
    start_run(SEED_A, 16'd10);
    wait_done(1'b1, cyc);
    check("alt_done_cycle", cyc,             20);
    check("alt_state",      bus.cur_state,   exp_st);
    check("alt_sig",        bus.signature,   exp_sg);
    check("alt_steps",      bus.steps_taken, 10);
    ack();

    // Abort after 3 steps, with pi_valid still high on the abort edge.
    model(SEED_A, 3, exp_st, exp_sg);
    start_run(SEED_A, 16'd10);
    bus.pi_valid = 1'b1;
    repeat (3) tick();
    check("abort_pre_steps", bus.steps_taken, 3);
    bus.abort = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.pi_valid = 1'b0;
    check("abort_start_ready", bus.start_ready, 1);
    check("abort_pi_ready",    bus.pi_ready,    0);
    check("abort_steps",       bus.steps_taken, 3);
    check("abort_state",       bus.cur_state,   exp_st);
    check("abort_sig",         bus.signature,   exp_sg);
    repeat (2) tick();
    check("abort_no_done",     bus.done,        0);

    // start held through RUN and DONE: no reload until back in IDLE.
    model(SEED_B, 4, exp_st, exp_sg);
    bus.seed     = SEED_B;
    bus.n_cycles = 16'd4;
    bus.start    = 1'b1;
    tick();
    bus.pi_valid = 1'b1;
    repeat (4) tick();
    bus.pi_valid = 1'b0;
    check("hold_done",      bus.done,      1);
    check("hold_state",     bus.cur_state, exp_st);
    tick();
    check("hold_state_d",   bus.cur_state,   exp_st);
    check("hold_sig_d",     bus.signature,   exp_sg);
    check("hold_steps_d",   bus.steps_taken, 4);
    check("hold_done_d",    bus.done,        1);
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
    check("hold_idle",       bus.start_ready, 1);
    check("hold_idle_state", bus.cur_state,   exp_st);
    tick();
    bus.start = 1'b0;
    check("reload_state",    bus.cur_state,   SEED_B);
    check("reload_sig",      bus.signature,   0);
    check("reload_steps",    bus.steps_taken, 0);
    check("reload_pi_ready", bus.pi_ready,    1);
    bus.pi_in = 3'b101;
    #1;
    check("comb_pi_pass",    bus.comb_pi,     3'b101);
    bus.pi_in = 3'b001;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of a run.
    start_run(SEED_A, 16'd10);
    bus.pi_valid = 1'b1;
    repeat (5) tick();
    check("mid_steps", bus.steps_taken, 5);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_state",       bus.cur_state,   0);
    check("mid_rst_sig",         bus.signature,   0);
    check("mid_rst_steps",       bus.steps_taken, 0);
    check("mid_rst_start_ready", bus.start_ready, 1);
    check("mid_rst_pi_ready",    bus.pi_ready,    0);
    check("mid_rst_done",        bus.done,        0);
    tick();
    rst          = 1'b0;
    bus.pi_valid = 1'b0;
    tick();
    check("post_rst_idle", bus.start_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s298_state_bank.md
Name: s298_state_bank

Overview:
- Sequential wrapper and run controller for the mapped s298 combinational netlist.
- Holds the 14 state flops and presents them to the comb block as current state. It captures the comb block's 14 next-state outputs and sequences N-cycle runs from a loaded seed.
- Compresses the six observable state bits into a MISR signature so mapped netlists can be checked against golden runs.

Parameters:
- NSTATE, 14, state width; fixed by the s298 netlist.
- CNT_W, 16, width of the run-length counter.
- MISR_W, 16, signature register width.
- MISR_POLY, 16'hB400, Galois feedback polynomial.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a run; accepted only when start_ready=1.
- start_ready  out  1  high in IDLE.
- seed  in  NSTATE  initial state, sampled on start acceptance.
- n_cycles  in  CNT_W  run length, sampled on start acceptance.
- pi_in  in  3  primary inputs {G2,G1,G0} for the current step.
- pi_valid  in  1  pi_in is valid this cycle.
- pi_ready  out  1  high in RUN; a step occurs when pi_valid & pi_ready.
- abort  in  1  cancel the run.
- cur_state  out  NSTATE  registered state to the comb block; bit order is defined in the package.
- comb_pi  out  3  pi_in passed straight through to the comb block.
- next_state  in  NSTATE  comb block next-state outputs.
- done  out  1  high in DONE.
- done_ack  in  1  releases DONE.
- signature  out  MISR_W  MISR value.
- steps_taken  out  CNT_W  count of completed steps in the current or last run.

Behaviour:
- Reset (async, rst=1): fsm=IDLE, cur_state=0, signature=0, steps_taken=0, remaining count=0, done=0, pi_ready=0, start_ready=1.
- States are IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start: cur_state<=seed, signature<=0, steps_taken<=0, remaining<=n_cycles.
  - Next state is DONE if n_cycles==0, otherwise RUN.
- RUN:
  - pi_ready=1.
  - On a step (pi_valid=1):
    - cur_state<=next_state.
    - signature<=MISR(signature, obs); obs is the 6 observable bits of the pre-step cur_state.
    - steps_taken++, remaining--.
  - If remaining==1 at the step, go to DONE.
  - pi_valid=0 stalls with no change to any register.
- DONE:
  - done=1; cur_state, signature and steps_taken are held stable.
  - done_ack returns to IDLE next cycle.
- Latency: state updates on the same edge that accepts the step. done asserts the cycle after the final step.
- MISR update: s = {sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0); then sig_next = s ^ zero-extended obs.
- Observable bit order obs[5:0] = {G67,G133,G66,G132,G118,G117}.
- abort:
  - In RUN: go to IDLE on the next edge. State and signature keep their current values; no step occurs that edge even if pi_valid=1.
  - Ignored in IDLE and DONE.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- steps_taken saturates at all-ones; it cannot overflow because remaining bounds it.
- rst asserted mid-RUN: immediate return to reset values; no partial step.

Decomposition:
- Package s298_pkg holds:
  - NSTATE and the index constants for each state bit: G10..G15, G22, G23, G66, G67, G117, G118, G132, G133.
  - The fsm state enum and MISR_POLY.
  - The observable-bit index list.
- One sub-module, s298_misr: combinational next-signature function plus register with clear. The controller and state bank stay in the top.

Test Plan:
- Reset mid-RUN: rst pulsed after 5 steps -> cur_state=0, signature=0, steps_taken=0, fsm=IDLE, start_ready=1 in the same cycle.
- n_cycles=0 with seed=14'h1234 -> DONE one cycle after start, cur_state=14'h1234, signature=0, steps_taken=0, pi_ready never high.
- Run of n_cycles=10 against the golden s298 model, pi_in=3'b001 (G0=1) every cycle, pi_valid continuous -> steps_taken=10, done exactly 11 cycles after start. cur_state and signature match the model's 10-step result.
- Same 10-cycle run with pi_valid deasserted on alternate cycles -> identical final cur_state and signature, done 20 cycles after start.
- abort after 3 steps -> IDLE next edge, steps_taken=3, cur_state equals the model's 3-step state, done never asserted.
- start held high during RUN and DONE -> no reload. After done_ack, the IDLE cycle with start=1 reloads the seed and clears signature.
